// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_INCR = 32'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        DROP  = ST_DROP,
        HOLD  = ST_HOLD
    } fetch_state_t;

    // Redirect targets are word addresses; the low two bits are forced to 0.
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, imem req/ack master, one-entry instruction buffer
// with valid/ready toward the core, and redirect/flush handling.
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] instr_pc,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_pc
);

    fetch_state_t       state;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] drop_addr;
    logic [INSTR_W-1:0] redirect_target;

    assign redirect_target = word_align(redirect_pc);

    always_comb begin
        imem_req  = (state == FETCH) || (state == DROP);
        imem_addr = (state == DROP) ? drop_addr : pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instruction <= NOP_WORD;
            instr_pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) pc <= redirect_target;
                    state <= FETCH;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                        // An outstanding request must still see its ack at the old address.
                        if (!imem_ack) begin
                            drop_addr <= pc;
                            state     <= DROP;
                        end
                    end else if (imem_ack) begin
                        instruction <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                DROP: begin
                    if (redirect_valid) pc <= redirect_target;
                    if (imem_ack) state <= FETCH;
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc          <= redirect_target;
                        instr_valid <= 1'b0;
                        instruction <= NOP_WORD;
                        state       <= FETCH;
                    end else if (instr_ready) begin
                        pc          <= pc + PC_INCR;
                        instr_valid <= 1'b0;
                        instruction <= NOP_WORD;
                        state       <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit; expectations hand-computed.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks;
    int failures;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[20];

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instruction(instruction),
        .instr_pc(instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic ack, input logic [31:0] rdata, input logic ready,
        input logic redir, input logic [31:0] rpc,
        input logic req, input logic [31:0] addr, input logic valid,
        input logic [31:0] instr, input logic [31:0] pc);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir; v.rpc = rpc;
        v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Outputs are all register-derived, so checking at the negedge before driving is safe.
    task automatic step(input string tag, input vec_t v);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, v.req});
        if (v.req) chk({tag, ".addr"}, imem_addr, v.addr);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v.valid});
        chk({tag, ".instr"}, instruction, v.instr);
        chk({tag, ".pc"}, instr_pc, v.pc);
        imem_ack       = v.ack;
        imem_rdata     = v.rdata;
        instr_ready    = v.ready;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        //            ack rdata          rdy rdv rpc   req addr  vld instr          pc
        vecs[0]  = mk(0, 32'h0,          0, 0, 32'h0, 0, 32'h0,  0, 32'h0,          32'h0);
        vecs[1]  = mk(0, 32'h0,          1, 0, 32'h0, 1, 32'h0,  0, 32'h0,          32'h0);
        vecs[2]  = mk(0, 32'h0,          1, 0, 32'h0, 1, 32'h0,  0, 32'h0,          32'h0);
        vecs[3]  = mk(1, 32'h2002_0005,  0, 0, 32'h0, 1, 32'h0,  0, 32'h0,          32'h0);
        vecs[4]  = mk(0, 32'h0,          0, 0, 32'h0, 0, 32'h0,  1, 32'h2002_0005,  32'h0);
        vecs[5]  = mk(1, 32'hBAAD_F00D,  0, 0, 32'h0, 0, 32'h0,  1, 32'h2002_0005,  32'h0);
        vecs[6]  = mk(0, 32'h0,          0, 0, 32'h0, 0, 32'h0,  1, 32'h2002_0005,  32'h0);
        vecs[7]  = mk(0, 32'h0,          0, 0, 32'h0, 0, 32'h0,  1, 32'h2002_0005,  32'h0);
        vecs[8]  = mk(0, 32'h0,          0, 0, 32'h0, 0, 32'h0,  1, 32'h2002_0005,  32'h0);
        vecs[9]  = mk(0, 32'h0,          1, 0, 32'h0, 0, 32'h0,  1, 32'h2002_0005,  32'h0);
        vecs[10] = mk(0, 32'h0,          1, 0, 32'h0, 1, 32'h4,  0, 32'h0,          32'h0);
        vecs[11] = mk(1, 32'h1111_0004,  1, 0, 32'h0, 1, 32'h4,  0, 32'h0,          32'h0);
        vecs[12] = mk(0, 32'h0,          1, 0, 32'h0, 0, 32'h4,  1, 32'h1111_0004,  32'h4);
        vecs[13] = mk(0, 32'h0,          1, 0, 32'h0, 1, 32'h8,  0, 32'h0,          32'h4);
        vecs[14] = mk(1, 32'h1111_0008,  1, 0, 32'h0, 1, 32'h8,  0, 32'h0,          32'h4);
        vecs[15] = mk(0, 32'h0,          1, 0, 32'h0, 0, 32'h8,  1, 32'h1111_0008,  32'h8);
        vecs[16] = mk(0, 32'h0,          1, 0, 32'h0, 1, 32'hC,  0, 32'h0,          32'h8);
        vecs[17] = mk(1, 32'h1111_000C,  1, 0, 32'h0, 1, 32'hC,  0, 32'h0,          32'h8);
        vecs[18] = mk(0, 32'h0,          1, 0, 32'h0, 0, 32'hC,  1, 32'h1111_000C,  32'hC);
        vecs[19] = mk(0, 32'h0,          0, 0, 32'h0, 1, 32'h10, 0, 32'h0,          32'hC);

        @(negedge clk);
        @(negedge clk);
        chk("rst.req",   {31'd0, imem_req},    32'd0);
        chk("rst.addr",  imem_addr,            32'h0);
        chk("rst.valid", {31'd0, instr_valid}, 32'd0);
        chk("rst.instr", instruction,          32'h0);
        chk("rst.pc",    instr_pc,             32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) step($sformatf("vec%0d", i), vecs[i]);

        // Redirect while FETCH is outstanding: old address held in DROP until ack.
        step("drop0", mk(0, 32'h0,         0, 1, 32'h0000_0103, 1, 32'h10,  0, 32'h0, 32'hC));
        step("drop1", mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h10,  0, 32'h0, 32'hC));
        step("drop2", mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h10,  0, 32'h0, 32'hC));
        step("drop3", mk(1, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 32'h10,  0, 32'h0, 32'hC));
        step("drop4", mk(1, 32'h1234_0100, 0, 0, 32'h0,         1, 32'h100, 0, 32'h0, 32'hC));
        step("drop5", mk(0, 32'h0,         1, 0, 32'h0,         0, 32'h100, 1, 32'h1234_0100, 32'h100));

        // Redirect coinciding with ack in FETCH, then with ready in HOLD.
        step("rack0", mk(1, 32'hBAD0_0104, 0, 1, 32'h0000_0200, 1, 32'h104, 0, 32'h0, 32'h100));
        step("rack1", mk(1, 32'hC000_0200, 0, 0, 32'h0,         1, 32'h200, 0, 32'h0, 32'h100));
        step("rrdy0", mk(0, 32'h0,         1, 1, 32'h0000_0300, 0, 32'h200, 1, 32'hC000_0200, 32'h200));
        step("rrdy1", mk(0, 32'h0,         0, 1, 32'h0000_0400, 1, 32'h300, 0, 32'h0, 32'h200));
        step("rrdy2", mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h300, 0, 32'h0, 32'h200));

        // Asynchronous reset in the middle of DROP, away from any clock edge.
        chk("mid.req", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.req",   {31'd0, imem_req},    32'd0);
        chk("arst.addr",  imem_addr,            32'h0);
        chk("arst.valid", {31'd0, instr_valid}, 32'd0);
        chk("arst.instr", instruction,          32'h0);
        chk("arst.pc",    instr_pc,             32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Redirect from IDLE to the last word; low target bits are ignored, then PC wraps.
        step("wrap0", mk(0, 32'h0,         0, 1, 32'hFFFF_FFFF, 0, 32'h0,         0, 32'h0, 32'h0));
        step("wrap1", mk(1, 32'h5555_AAAA, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0));
        step("wrap2", mk(0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h5555_AAAA, 32'hFFFF_FFFC));
        step("wrap3", mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0, 32'hFFFF_FFFC));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
